// File: rtl/data_sync_pkg.sv
// Shared types and defaults for the multi-bit bus-synchronizer transmitter and receiver.
package data_sync_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SETUP = 2'b01,
        REQ   = 2'b10,
        REL   = 2'b11
    } tx_state_t;

    localparam int DEF_BUS_WIDTH  = 8;
    localparam int DEF_NUM_STAGES = 2;

endpackage

// File: rtl/data_sync_tx_if.sv
// Word-in / bus-out signal bundle of the source-domain transmitter.
interface data_sync_tx_if
    import data_sync_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH
);
    logic [BUS_WIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [BUS_WIDTH-1:0] Unsync_bus;
    logic                 bus_enable;
    logic                 ack_async;
    logic                 tx_done;
    logic                 timeout_err;

    modport master (
        input  in_data, in_valid, ack_async,
        output in_ready, Unsync_bus, bus_enable, tx_done, timeout_err
    );

    modport slave (
        output in_data, in_valid, ack_async,
        input  in_ready, Unsync_bus, bus_enable, tx_done, timeout_err
    );
endinterface

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchronizer with synchronous active-low reset.
module bit_sync #(
    parameter int NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);
    logic [NUM_STAGES-1:0] chain_r;

    // Shift the asynchronous level through the synchronizer chain
    always_ff @(posedge CLK) begin
        if (!RST) begin
            chain_r <= {NUM_STAGES{1'b0}};
        end else begin
            chain_r <= {chain_r[NUM_STAGES-2:0], d};
        end
    end

    assign q = chain_r[NUM_STAGES-1];
endmodule

// File: rtl/data_sync_tx.sv
// Source-domain transmitter: launches a stable bus plus a req level and runs a 4-phase handshake.
// Optional handshake timeout enabled by defining ACK_TIMEOUT_EN.
module data_sync_tx
    import data_sync_pkg::*;
#(
    parameter int BUS_WIDTH      = DEF_BUS_WIDTH,
    parameter int NUM_STAGES     = DEF_NUM_STAGES,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic           CLK,
    input  logic           RST,
    data_sync_tx_if.master tx
);
    if (NUM_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("data_sync_tx: NUM_STAGES and TIMEOUT_CYCLES must both be >= 2");
    end

    tx_state_t            state_r;
    logic [BUS_WIDTH-1:0] bus_r;
    logic                 en_r;
    logic                 done_r;
    logic                 ack_sync_s;
    logic                 ready_s;

    bit_sync #(.NUM_STAGES(NUM_STAGES)) u_ack_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (tx.ack_async),
        .q   (ack_sync_s)
    );

    // A stale ack must clear before a new request may start
    assign ready_s = (state_r == IDLE) && !ack_sync_s;

`ifdef ACK_TIMEOUT_EN
    localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             terr_r;
    logic             limit_s;

    assign limit_s = (cnt_r == CNT_LIMIT);
`endif

    // Handshake FSM; the exit condition is tested before the timeout so it wins a tie
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r <= IDLE;
            bus_r   <= {BUS_WIDTH{1'b0}};
            en_r    <= 1'b0;
            done_r  <= 1'b0;
`ifdef ACK_TIMEOUT_EN
            cnt_r   <= {CNT_W{1'b0}};
            terr_r  <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
`ifdef ACK_TIMEOUT_EN
            terr_r <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (tx.in_valid && ready_s) begin
                        bus_r   <= tx.in_data;
                        state_r <= SETUP;
                    end
                end
                SETUP: begin
                    en_r    <= 1'b1;
                    state_r <= REQ;
`ifdef ACK_TIMEOUT_EN
                    cnt_r   <= {CNT_W{1'b0}};
`endif
                end
                REQ: begin
                    if (ack_sync_s) begin
                        en_r    <= 1'b0;
                        state_r <= REL;
`ifdef ACK_TIMEOUT_EN
                        cnt_r   <= {CNT_W{1'b0}};
                    end else if (limit_s) begin
                        en_r    <= 1'b0;
                        terr_r  <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
`endif
                    end
                end
                REL: begin
                    if (!ack_sync_s) begin
                        done_r  <= 1'b1;
                        state_r <= IDLE;
`ifdef ACK_TIMEOUT_EN
                    end else if (limit_s) begin
                        en_r    <= 1'b0;
                        terr_r  <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
`endif
                    end
                end
                default: begin
                    en_r    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign tx.in_ready   = ready_s;
    assign tx.Unsync_bus = bus_r;
    assign tx.bus_enable = en_r;
    assign tx.tx_done    = done_r;
`ifdef ACK_TIMEOUT_EN
    assign tx.timeout_err = terr_r;
`else
    assign tx.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_data_sync_tx.sv
// Self-checking bench for data_sync_tx: directed and randomized handshakes against timing rules.
module tb_data_sync_tx;
    import data_sync_pkg::*;

    localparam int BW = 8;
    localparam int NS = 2;
    localparam int TO = 16;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    data_sync_tx_if #(.BUS_WIDTH(BW)) ifc ();

    data_sync_tx #(
        .BUS_WIDTH      (BW),
        .NUM_STAGES     (NS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .tx  (ifc.master)
    );

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int terr_seen = 0;
    int done_exp = 0;
    logic [BW-1:0] exp_bus = 8'h00;

    // Pulse counters sampled on the inactive edge
    always @(negedge CLK) begin
        if (ifc.tx_done === 1'b1) done_seen++;
        if (ifc.timeout_err === 1'b1) terr_seen++;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return ifc.bus_enable;
            1:       return ifc.tx_done;
            2:       return ifc.in_ready;
            default: return ifc.timeout_err;
        endcase
    endfunction

    // Step until the selected output reaches val; n = cycles taken (limit if never)
    task automatic wait_for(input int which, input logic val, input int limit, output int n);
        n = 0;
        while (sig(which) !== val && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic accept(input logic [BW-1:0] data);
        int n;
        wait_for(2, 1'b1, 50, n);
        check("ready_before_accept", 32'(ifc.in_ready), 32'd1);
        ifc.in_data  = data;
        ifc.in_valid = 1'b1;
        step();
        ifc.in_valid = 1'b0;
        exp_bus = data;
        check("bus_at_accept", 32'(ifc.Unsync_bus), 32'(exp_bus));
        check("en_low_setup", 32'(ifc.bus_enable), 32'd0);
        check("ready_low_busy", 32'(ifc.in_ready), 32'd0);
        step();
        check("en_rise_T1", 32'(ifc.bus_enable), 32'd1);
    endtask

    task automatic transfer(input logic [BW-1:0] data, input int d1, input int d2,
                            input logic junk, input logic [BW-1:0] junk_data);
        int n;
        accept(data);
        if (junk) begin
            ifc.in_data  = junk_data;
            ifc.in_valid = 1'b1;
        end
        for (int i = 0; i < d1; i++) begin
            step();
            check("en_held_req", 32'(ifc.bus_enable), 32'd1);
        end
        ifc.ack_async = 1'b1;
        wait_for(0, 1'b0, 40, n);
        check("en_fall_delay", 32'(n), 32'(NS + 1));
        check("bus_stable_req", 32'(ifc.Unsync_bus), 32'(exp_bus));
        check("no_done_in_req", 32'(ifc.tx_done), 32'd0);
        for (int i = 0; i < d2; i++) begin
            step();
            check("en_held_rel", 32'(ifc.bus_enable), 32'd0);
        end
        ifc.ack_async = 1'b0;
        wait_for(1, 1'b1, 40, n);
        check("done_delay", 32'(n), 32'(NS + 1));
        check("ready_after_done", 32'(ifc.in_ready), 32'd1);
        check("bus_stable_rel", 32'(ifc.Unsync_bus), 32'(exp_bus));
        ifc.in_valid = 1'b0;
        done_exp++;
        step();
        check("done_one_cycle", 32'(ifc.tx_done), 32'd0);
        check("bus_kept_idle", 32'(ifc.Unsync_bus), 32'(exp_bus));
    endtask

    initial begin
        int n;
        ifc.in_data   = 8'h00;
        ifc.in_valid  = 1'b0;
        ifc.ack_async = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_bus", 32'(ifc.Unsync_bus), 32'd0);
        check("rst_en", 32'(ifc.bus_enable), 32'd0);
        check("rst_done", 32'(ifc.tx_done), 32'd0);
        check("rst_terr", 32'(ifc.timeout_err), 32'd0);
        RST = 1'b1;
        step();
        check("first_ready", 32'(ifc.in_ready), 32'd1);
        check("first_bus", 32'(ifc.Unsync_bus), 32'd0);
        check("first_en", 32'(ifc.bus_enable), 32'd0);

        // Directed A5 with 3C offered while busy
        transfer(8'hA5, 3, 3, 1'b1, 8'h3C);

        // Stale ack at IDLE blocks acceptance
        ifc.ack_async = 1'b1;
        repeat (NS) step();
        check("stale_ready_low", 32'(ifc.in_ready), 32'd0);
        ifc.in_data  = 8'h77;
        ifc.in_valid = 1'b1;
        repeat (4) step();
        check("stale_no_accept", 32'(ifc.Unsync_bus), 32'(exp_bus));
        check("stale_en_low", 32'(ifc.bus_enable), 32'd0);
        ifc.in_valid  = 1'b0;
        ifc.ack_async = 1'b0;
        wait_for(2, 1'b1, 20, n);
        check("stale_clear_delay", 32'(n), 32'(NS));

        // Randomized transfers
        for (int t = 0; t < 6; t++) begin
            transfer(BW'($urandom), $urandom_range(1, 6), $urandom_range(1, 6),
                     1'($urandom_range(0, 1)), BW'($urandom));
        end

        // Reset during REQ
        accept(8'h5A);
        step();
        RST = 1'b0;
        step();
        exp_bus = 8'h00;
        check("midrst_en", 32'(ifc.bus_enable), 32'd0);
        check("midrst_bus", 32'(ifc.Unsync_bus), 32'(exp_bus));
        check("midrst_done", 32'(ifc.tx_done), 32'd0);
        check("midrst_idle", 32'(ifc.in_ready), 32'd1);
        RST = 1'b1;
        step();
        check("midrst_no_done", 32'(ifc.tx_done), 32'd0);

`ifdef ACK_TIMEOUT_EN
        accept(8'hC3);
        wait_for(0, 1'b0, 100, n);
        check("to_req_cycles", 32'(n), 32'(TO));
        check("to_err_pulse", 32'(ifc.timeout_err), 32'd1);
        check("to_ready", 32'(ifc.in_ready), 32'd1);
        check("to_no_done", 32'(ifc.tx_done), 32'd0);
        step();
        check("to_err_one_cycle", 32'(ifc.timeout_err), 32'd0);
        check("to_err_count", 32'(terr_seen), 32'd1);
`else
        transfer(8'hC3, 40, 2, 1'b0, 8'h00);
        check("no_timeout_err", 32'(terr_seen), 32'd0);
`endif
        repeat (2) step();
        check("done_pulse_count", 32'(done_seen), 32'(done_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
